// File: rtl/lc_to_cell_9_9.sv
// lc_to_cell_9_9: encodes two (line,col) pairs of a 9x9 grid into flat cell
// indices (cell = line*9 + col) through a two-stage valid/ready pipeline, with
// per-pair range flags and a saturating count of delivered error results.
module lc_to_cell_9_9 #(
    parameter int unsigned LC_W   = 4,
    parameter int unsigned CELL_W = 7,
    parameter int unsigned ERRC_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [LC_W-1:0]   l1,
    input  logic [LC_W-1:0]   c1,
    input  logic [LC_W-1:0]   l2,
    input  logic [LC_W-1:0]   c2,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CELL_W-1:0] cell1,
    output logic [CELL_W-1:0] cell2,
    output logic [1:0]        out_err,
    output logic [ERRC_W-1:0] err_count
);

    localparam int unsigned N_LINES = 9;
    localparam int unsigned N_COLS  = 9;
    // Wide enough for 15*9 so out-of-range lines never wrap the product.
    localparam int unsigned PROD_W  = LC_W + 4;

    // line*9 as a shift-and-add.
    function automatic logic [PROD_W-1:0] times9(input logic [LC_W-1:0] l);
        return (PROD_W'(l) << 3) + PROD_W'(l);
    endfunction

    function automatic logic out_of_range(input logic [LC_W-1:0] l,
                                          input logic [LC_W-1:0] c);
        return (l >= LC_W'(N_LINES)) || (c >= LC_W'(N_COLS));
    endfunction

    logic              s1_valid_q, s1_valid_d;
    logic [PROD_W-1:0] s1_prod1_q, s1_prod1_d;
    logic [PROD_W-1:0] s1_prod2_q, s1_prod2_d;
    logic [LC_W-1:0]   s1_col1_q,  s1_col1_d;
    logic [LC_W-1:0]   s1_col2_q,  s1_col2_d;
    logic [1:0]        s1_err_q,   s1_err_d;

    logic              s2_valid_q, s2_valid_d;
    logic [CELL_W-1:0] cell1_q,    cell1_d;
    logic [CELL_W-1:0] cell2_q,    cell2_d;
    logic [1:0]        err_q,      err_d;
    logic [ERRC_W-1:0] err_count_q, err_count_d;

    logic s2_adv;
    logic s1_adv;

    // Handshake: a stage moves when it is empty or the stage after it moves.
    always_comb begin
        s2_adv   = !s2_valid_q || out_ready;
        s1_adv   = !s1_valid_q || s2_adv;
        in_ready = s1_adv;
    end

    // Stage 1: line products, columns and range flags.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_prod1_d = s1_prod1_q;
        s1_prod2_d = s1_prod2_q;
        s1_col1_d  = s1_col1_q;
        s1_col2_d  = s1_col2_q;
        s1_err_d   = s1_err_q;
        if (s1_adv) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_prod1_d = times9(l1);
                s1_prod2_d = times9(l2);
                s1_col1_d  = c1;
                s1_col2_d  = c2;
                s1_err_d   = {out_of_range(l2, c2), out_of_range(l1, c1)};
            end
        end
    end

    // Stage 2: final cell indices, zeroed for out-of-range pairs; holds while stalled.
    always_comb begin
        s2_valid_d = s2_valid_q;
        cell1_d    = cell1_q;
        cell2_d    = cell2_q;
        err_d      = err_q;
        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                cell1_d = s1_err_q[0] ? '0 : CELL_W'(s1_prod1_q + PROD_W'(s1_col1_q));
                cell2_d = s1_err_q[1] ? '0 : CELL_W'(s1_prod2_q + PROD_W'(s1_col2_q));
                err_d   = s1_err_q;
            end
        end
    end

    // Saturating count of delivered results carrying any error flag.
    always_comb begin
        err_count_d = err_count_q;
        if (s2_valid_q && out_ready && (|err_q) && (err_count_q != '1)) begin
            err_count_d = err_count_q + ERRC_W'(1);
        end
    end

    // Pipeline and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_prod1_q  <= '0;
            s1_prod2_q  <= '0;
            s1_col1_q   <= '0;
            s1_col2_q   <= '0;
            s1_err_q    <= '0;
            s2_valid_q  <= 1'b0;
            cell1_q     <= '0;
            cell2_q     <= '0;
            err_q       <= '0;
            err_count_q <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_prod1_q  <= s1_prod1_d;
            s1_prod2_q  <= s1_prod2_d;
            s1_col1_q   <= s1_col1_d;
            s1_col2_q   <= s1_col2_d;
            s1_err_q    <= s1_err_d;
            s2_valid_q  <= s2_valid_d;
            cell1_q     <= cell1_d;
            cell2_q     <= cell2_d;
            err_q       <= err_d;
            err_count_q <= err_count_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign cell1     = cell1_q;
    assign cell2     = cell2_q;
    assign out_err   = err_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_lc_to_cell_9_9.sv
// Bench for lc_to_cell_9_9: a queue-based transaction model checked every
// cycle, directed scenarios with literal expectations, and random traffic.
// A second instance with a 4-bit error counter exercises saturation.
module tb_lc_to_cell_9_9;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       out_ready;
    logic [3:0] l1, c1, l2, c2;

    logic       in_ready,  in_ready_s;
    logic       out_valid, out_valid_s;
    logic [6:0] cell1, cell2, cell1_s, cell2_s;
    logic [1:0] out_err, out_err_s;
    logic [15:0] err_count;
    logic [3:0]  err_count_s;

    lc_to_cell_9_9 dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .l1(l1), .c1(c1), .l2(l2), .c2(c2),
        .out_valid(out_valid), .out_ready(out_ready),
        .cell1(cell1), .cell2(cell2), .out_err(out_err), .err_count(err_count)
    );

    lc_to_cell_9_9 #(.ERRC_W(4)) dut_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
        .l1(l1), .c1(c1), .l2(l2), .c2(c2),
        .out_valid(out_valid_s), .out_ready(out_ready),
        .cell1(cell1_s), .cell2(cell2_s), .out_err(out_err_s), .err_count(err_count_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int c1;
        int c2;
        int err;
        int acc_edge;
    } item_t;

    item_t q[$];
    int    edges = 0;
    int    ec    = 0;
    int    ecs   = 0;

    function automatic item_t encode(input int la, input int ca, input int lb, input int cb,
                                     input int e);
        item_t it;
        bit ea, eb;
        ea = (la >= 9) || (ca >= 9);
        eb = (lb >= 9) || (cb >= 9);
        it.c1 = ea ? 0 : la * 9 + ca;
        it.c2 = eb ? 0 : lb * 9 + cb;
        it.err = (eb ? 2 : 0) + (ea ? 1 : 0);
        it.acc_edge = e;
        return it;
    endfunction

    // Check the present outputs, then advance the model across the coming edge.
    always @(negedge clk) begin
        bit exp_ov, exp_ir;
        if (!rst_n) begin
            q.delete();
            edges = 0;
            ec    = 0;
            ecs   = 0;
            chk("rst_out_valid", int'(out_valid), 0);
            chk("rst_cell1",     int'(cell1), 0);
            chk("rst_cell2",     int'(cell2), 0);
            chk("rst_out_err",   int'(out_err), 0);
            chk("rst_err_count", int'(err_count), 0);
        end else begin
            exp_ov = 1'b0;
            if (q.size() > 0) exp_ov = (q[0].acc_edge < edges);
            exp_ir = !((q.size() == 2) && !out_ready);
            chk("out_valid",   int'(out_valid), int'(exp_ov));
            chk("out_valid_s", int'(out_valid_s), int'(exp_ov));
            chk("in_ready",    int'(in_ready), int'(exp_ir));
            chk("err_count",   int'(err_count), ec);
            chk("err_count_s", int'(err_count_s), ecs);
            if (exp_ov) begin
                chk("cell1",   int'(cell1), q[0].c1);
                chk("cell2",   int'(cell2), q[0].c2);
                chk("out_err", int'(out_err), q[0].err);
            end
            edges++;
            if (exp_ov && out_ready) begin
                if (q[0].err != 0) begin
                    if (ec < 65535) ec++;
                    if (ecs < 15) ecs++;
                end
                void'(q.pop_front());
            end
            if (in_valid && exp_ir)
                q.push_back(encode(int'(l1), int'(c1), int'(l2), int'(c2), edges));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic align();
        @(posedge clk);
        #2;
    endtask

    // Present one pair until accepted; caller is aligned just after a rising edge.
    task automatic send(input int la, input int ca, input int lb, input int cb);
        bit ok;
        ok = 1'b0;
        in_valid = 1'b1;
        l1 = 4'(la); c1 = 4'(ca); l2 = 4'(lb); c2 = 4'(cb);
        for (int t = 0; t < 64 && !ok; t++) begin
            @(negedge clk);
            ok = in_ready;
            align();
        end
        if (!ok) chk("send_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    function automatic int rnd_coord();
        if ($urandom_range(0, 9) < 7) return int'($urandom_range(0, 8));
        return int'($urandom_range(0, 15));
    endfunction

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        l1 = '0; c1 = '0; l2 = '0; c2 = '0;
        #22 rst_n = 1'b1;
        align();

        // Corner pair: (0,0) and (8,8).
        out_ready = 1'b1;
        send(0, 0, 8, 8);
        @(posedge clk); @(negedge clk); #1;
        chk("t1_out_valid", int'(out_valid), 1);
        chk("t1_cell1",     int'(cell1), 0);
        chk("t1_cell2",     int'(cell2), 80);
        chk("t1_out_err",   int'(out_err), 0);
        align();

        // Every valid coordinate, back to back.
        for (int l = 0; l < 9; l++)
            for (int c = 0; c < 9; c++)
                send(l, c, 8 - l, 8 - c);
        repeat (3) align();
        chk("t2_err_count", int'(err_count), 0);

        // Range errors on each pair independently.
        send(9, 0, 4, 5);
        @(posedge clk); @(negedge clk); #1;
        chk("t3_cell1",   int'(cell1), 0);
        chk("t3_cell2",   int'(cell2), 41);
        chk("t3_out_err", int'(out_err), 1);
        @(posedge clk); @(negedge clk); #1;
        chk("t3_err_count1", int'(err_count), 1);
        align();
        send(15, 15, 0, 9);
        @(posedge clk); @(negedge clk); #1;
        chk("t3_out_err2", int'(out_err), 3);
        chk("t3_cell1b",   int'(cell1), 0);
        chk("t3_cell2b",   int'(cell2), 0);
        @(posedge clk); @(negedge clk); #1;
        chk("t3_err_count2", int'(err_count), 2);
        align();

        // Backpressure: four pairs against a stalled output.
        out_ready = 1'b0;
        fork
            begin
                send(1, 2, 3, 4);
                send(5, 6, 7, 8);
                send(2, 2, 6, 6);
                send(8, 0, 0, 8);
            end
            begin
                repeat (3) @(negedge clk);
                #1;
                chk("t4_in_ready_low", int'(in_ready), 0);
                chk("t4_cell1_held",   int'(cell1), 11);
                align();
                repeat (3) align();
                out_ready = 1'b1;
            end
        join
        repeat (4) align();

        // Random traffic with random stalls.
        for (int i = 0; i < 600; i++) begin
            in_valid  = ($urandom_range(0, 2) != 0);
            l1 = 4'(rnd_coord()); c1 = 4'(rnd_coord());
            l2 = 4'(rnd_coord()); c2 = 4'(rnd_coord());
            out_ready = ($urandom_range(0, 3) != 0);
            align();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (4) align();

        // Enough errors to pin the narrow counter at all-ones.
        for (int i = 0; i < 20; i++) send(9, 9, 15, 0);
        repeat (4) align();
        chk("t5_sat_count", int'(err_count_s), 15);

        // Reset with both stages full.
        out_ready = 1'b0;
        in_valid = 1'b1;
        l1 = 4'd3; c1 = 4'd3; l2 = 4'd4; c2 = 4'd4;
        repeat (3) align();
        @(negedge clk); #3;
        rst_n = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("t6_out_valid", int'(out_valid), 0);
        chk("t6_err_count", int'(err_count), 0);
        chk("t6_err_count_s", int'(err_count_s), 0);
        align();
        align();
        rst_n = 1'b1;
        #1;
        chk("t6_in_ready", int'(in_ready), 1);
        for (int i = 0; i < 40; i++) begin
            in_valid  = ($urandom_range(0, 1) != 0);
            l1 = 4'(rnd_coord()); c1 = 4'(rnd_coord());
            l2 = 4'(rnd_coord()); c2 = 4'(rnd_coord());
            out_ready = ($urandom_range(0, 3) != 0);
            align();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (4) align();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
